// File: rtl/hps_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hps_dma_pkg
//  Description : Shared types and sizing helpers for the HPS DMA bridge.
//  Revision    : 1.0  initial release
// ============================================================================
package hps_dma_pkg;

    // Bridge controller states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        HIT     = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    // Bytes per data word
    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    // Width able to hold a burst count of exactly DEPTH
    function automatic int bcnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hps_dma_bridge_activity_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : activity_stretch
//  Description : Stretches a busy level by HOLD cycles after it falls, for an
//                activity LED. Any busy cycle reloads the hold counter.
//  Revision    : 1.0  initial release
// ============================================================================
module activity_stretch
    import hps_dma_pkg::*;
#(
    parameter int HOLD = 4500000
)(
    input  logic clk_sys_i,
    input  logic reset_n_i,
    input  logic busy_i,
    output logic active_o
);

    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] cnt_q;

    // Reload while busy, otherwise count down to zero
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else if (busy_i) begin
            cnt_q <= CW'(HOLD);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign active_o = busy_i | (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hps_dma_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : hps_dma_bridge
//  Description : Converts HPS single-word DMA pulses into Avalon-MM
//                transactions. Optional burst-read prefetch buffer, safe abort
//                with beat draining, and a stretched activity output.
//                Prefetch is enabled by defining HPS_DMA_PREFETCH_EN; without
//                it every read is a single-beat burst.
//  Revision    : 1.0  initial release
// ============================================================================
module hps_dma_bridge
    import hps_dma_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int LED_HOLD = 4500000
)(
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         abort,
    input  logic [ADDR_W-1:0]            dma_addr,
    input  logic                         dma_rd,
    input  logic                         dma_wr,
    input  logic [DATA_W-1:0]            dma_dout,
    output logic [DATA_W-1:0]            dma_din,
    output logic                         dma_wait,
    output logic [ADDR_W-1:0]            mem_address,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [DATA_W-1:0]            mem_writedata,
    output logic [bcnt_width(DEPTH)-1:0] mem_burstcount,
    input  logic                         mem_waitrequest,
    input  logic [DATA_W-1:0]            mem_readdata,
    input  logic                         mem_readdatavalid,
    output logic                         activity
);

    localparam int BCW = bcnt_width(DEPTH);
`ifdef HPS_DMA_PREFETCH_EN
    localparam int BURST_LEN = DEPTH;
`else
    localparam int BURST_LEN = 1;
`endif
    localparam logic [BCW-1:0] BURST_BC  = BCW'(BURST_LEN);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

    state_t             state_q;
    logic [BCW-1:0]     beat_q;
    logic               abort_pend_q;
    logic [DATA_W-1:0]  dma_din_q;
    logic               dma_wait_q;
    logic [ADDR_W-1:0]  mem_address_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [DATA_W-1:0]  mem_writedata_q;
    logic [BCW-1:0]     mem_burstcount_q;

    logic               w_beat_last;

    // The final beat of the current burst is on the bus this cycle
    assign w_beat_last = mem_readdatavalid && (beat_q == LAST_BEAT);

`ifdef HPS_DMA_PREFETCH_EN
    localparam int BYTES = bytes_of(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * BYTES);

    logic [DATA_W-1:0]  buf_q [DEPTH];
    logic               buf_valid_q;
    logic [ADDR_W-1:0]  base_q;
    logic [IDX_W-1:0]   hit_idx_q;
    logic [ADDR_W-1:0]  w_offset;
    logic               w_hit;

    // Modulo subtraction makes a window that straddles address wrap still hit
    assign w_offset = dma_addr - base_q;
    assign w_hit    = buf_valid_q && (w_offset < SPAN);

    // Burst beats land in the buffer slot matching their beat number
    always_ff @(posedge clk_sys) begin
        if (state_q == RD_DATA && mem_readdatavalid) begin
            buf_q[beat_q[IDX_W-1:0]] <= mem_readdata;
        end
    end
`endif

    // Request/response controller with registered outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            beat_q           <= '0;
            abort_pend_q     <= 1'b0;
            dma_din_q        <= '0;
            dma_wait_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_burstcount_q <= '0;
`ifdef HPS_DMA_PREFETCH_EN
            buf_valid_q      <= 1'b0;
            base_q           <= '0;
            hit_idx_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (abort) begin
`ifdef HPS_DMA_PREFETCH_EN
                        buf_valid_q <= 1'b0;
`endif
                    end else if (dma_wr) begin
                        // Write wins over a simultaneous read
                        mem_write_q      <= 1'b1;
                        mem_address_q    <= dma_addr;
                        mem_writedata_q  <= dma_dout;
                        mem_burstcount_q <= BCW'(1);
                        dma_wait_q       <= 1'b1;
                        abort_pend_q     <= 1'b0;
                        state_q          <= WR_REQ;
`ifdef HPS_DMA_PREFETCH_EN
                        buf_valid_q      <= 1'b0;
`endif
                    end else if (dma_rd) begin
                        dma_wait_q <= 1'b1;
`ifdef HPS_DMA_PREFETCH_EN
                        if (w_hit) begin
                            hit_idx_q <= w_offset[OFF_W +: IDX_W];
                            state_q   <= HIT;
                        end else begin
                            mem_read_q       <= 1'b1;
                            mem_address_q    <= dma_addr;
                            mem_burstcount_q <= BURST_BC;
                            beat_q           <= '0;
                            abort_pend_q     <= 1'b0;
                            base_q           <= dma_addr;
                            state_q          <= RD_REQ;
                        end
`else
                        mem_read_q       <= 1'b1;
                        mem_address_q    <= dma_addr;
                        mem_burstcount_q <= BURST_BC;
                        beat_q           <= '0;
                        abort_pend_q     <= 1'b0;
                        state_q          <= RD_REQ;
`endif
                    end
                end

                RD_REQ: begin
                    // The command cannot be withdrawn; an abort only releases the HPS
                    if (abort) begin
                        abort_pend_q <= 1'b1;
                        dma_wait_q   <= 1'b0;
`ifdef HPS_DMA_PREFETCH_EN
                        buf_valid_q  <= 1'b0;
`endif
                    end
                    if (!mem_waitrequest) begin
                        mem_read_q <= 1'b0;
                        state_q    <= (abort || abort_pend_q) ? DRAIN : RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (mem_readdatavalid) begin
                        beat_q <= beat_q + BCW'(1);
                        if (beat_q == '0) begin
                            dma_din_q <= mem_readdata;
                        end
                    end
                    if (abort) begin
                        dma_wait_q <= 1'b0;
                        state_q    <= w_beat_last ? IDLE : DRAIN;
`ifdef HPS_DMA_PREFETCH_EN
                        buf_valid_q <= 1'b0;
`endif
                    end else if (w_beat_last) begin
                        dma_wait_q <= 1'b0;
                        state_q    <= IDLE;
`ifdef HPS_DMA_PREFETCH_EN
                        buf_valid_q <= 1'b1;
`endif
                    end
                end

                WR_REQ: begin
                    if (abort) begin
                        dma_wait_q <= 1'b0;
                    end
                    if (!mem_waitrequest) begin
                        mem_write_q <= 1'b0;
                        dma_wait_q  <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

`ifdef HPS_DMA_PREFETCH_EN
                HIT: begin
                    dma_din_q  <= buf_q[hit_idx_q];
                    dma_wait_q <= 1'b0;
                    state_q    <= IDLE;
                    if (abort) begin
                        buf_valid_q <= 1'b0;
                    end
                end
`endif

                DRAIN: begin
                    // Swallow the rest of the burst so no stray beat is misread later
                    if (mem_readdatavalid) begin
                        beat_q <= beat_q + BCW'(1);
                    end
                    if (w_beat_last) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dma_din        = dma_din_q;
    assign dma_wait       = dma_wait_q;
    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_burstcount = mem_burstcount_q;

    activity_stretch #(
        .HOLD (LED_HOLD)
    ) u_activity (
        .clk_sys_i (clk_sys),
        .reset_n_i (reset_n),
        .busy_i    (dma_wait_q),
        .active_o  (activity)
    );

endmodule
`default_nettype wire

// File: tb/tb_hps_dma_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hps_dma_bridge
//  Description : Self-checking bench for hps_dma_bridge: Avalon memory slave
//                with random backpressure/beat gaps, a prefetch-aware reference
//                model, a directed vector table and randomized traffic.
//                Follows HPS_DMA_PREFETCH_EN the same way as the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hps_dma_bridge;

`ifdef HPS_DMA_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    localparam int DEPTH = 8;
    localparam logic [3:0]  BL   = PF ? 4'd8 : 4'd1;
    localparam logic [31:0] SPAN = 32'd32;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        abort;
    logic [31:0] dma_addr;
    logic        dma_rd;
    logic        dma_wr;
    logic [31:0] dma_dout;
    logic [31:0] dma_din;
    logic        dma_wait;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_burstcount;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        activity;

    hps_dma_bridge #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .LED_HOLD (10)
    ) dut (
        .clk_sys           (clk_sys),
        .reset_n           (reset_n),
        .abort             (abort),
        .dma_addr          (dma_addr),
        .dma_rd            (dma_rd),
        .dma_wr            (dma_wr),
        .dma_dout          (dma_dout),
        .dma_din           (dma_din),
        .dma_wait          (dma_wait),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_burstcount    (mem_burstcount),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .activity          (activity)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Initial memory contents, distinct per word
    function automatic logic [31:0] ini(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // ---------------- Avalon memory slave ----------------
    logic [31:0] smem [logic [31:0]];
    logic [31:0] addr_q [$];
    int unsigned cyc = 0;
    int unsigned stall_until = 0;
    int unsigned beat_limit = 32'hFFFF_FFFF;
    int unsigned beats_sent = 0;
    int unsigned rd_cmds = 0;
    int unsigned wr_cmds = 0;
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
    logic [3:0]  last_rd_bc, last_wr_bc;

    function automatic logic [31:0] sget(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : ini(a);
    endfunction

    always @(negedge clk_sys) begin
        cyc++;
        if (!reset_n) begin
            mem_waitrequest   = 1'b0;
            mem_readdatavalid = 1'b0;
            mem_readdata      = '0;
            addr_q.delete();
        end else begin
            mem_waitrequest = (cyc <= stall_until) ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (addr_q.size() > 0 && beats_sent < beat_limit && $urandom_range(0, 3) != 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = sget(addr_q.pop_front());
                beats_sent++;
            end else begin
                mem_readdatavalid = 1'b0;
            end
            if (mem_read && !mem_waitrequest) begin
                for (int k = 0; k < int'(mem_burstcount); k++) addr_q.push_back(mem_address + 32'(4 * k));
                rd_cmds++;
                last_rd_addr = mem_address;
                last_rd_bc   = mem_burstcount;
            end
            if (mem_write && !mem_waitrequest) begin
                smem[mem_address] = mem_writedata;
                wr_cmds++;
                last_wr_addr = mem_address;
                last_wr_data = mem_writedata;
                last_wr_bc   = mem_burstcount;
            end
        end
    end

    // ---------------- Reference model ----------------
    logic [31:0] rmem [logic [31:0]];
    bit          m_valid = 1'b0;
    logic [31:0] m_base  = '0;

    function automatic void model_predict(input bit rd, input bit wr, input logic [31:0] a,
                                          input logic [31:0] d, output bit eh, output logic [31:0] ed);
        logic [31:0] off;
        eh = 1'b0;
        ed = '0;
        if (wr) begin
            rmem[a] = d;
            m_valid = 1'b0;
        end else if (rd) begin
            off = a - m_base;
            eh  = PF && m_valid && (off < SPAN);
            ed  = rmem.exists(a) ? rmem[a] : ini(a);
            if (!eh) begin
                m_valid = PF;
                m_base  = a;
            end
        end
    endfunction

    // ---------------- Helpers ----------------
    typedef struct {
        logic [31:0] dout;
        int          lat;
        int          rdc;
        int          wrc;
        logic        busy;
        bit          to;
    } res_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_hit;
    } vec_t;

    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One DMA request; returns when dma_wait is seen low
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output res_t r);
        int unsigned rd0 = rd_cmds;
        int unsigned wr0 = wr_cmds;
        dma_rd = rd; dma_wr = wr; dma_addr = a; dma_dout = d;
        step();
        dma_rd = 1'b0; dma_wr = 1'b0;
        r.busy = dma_wait;
        r.lat  = 1;
        r.to   = 1'b0;
        while (dma_wait !== 1'b0) begin
            if (r.lat > 300) begin
                r.to = 1'b1;
                break;
            end
            step();
            r.lat++;
        end
        r.dout = dma_din;
        r.rdc  = int'(rd_cmds - rd0);
        r.wrc  = int'(wr_cmds - wr0);
    endtask

    task automatic check_op(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input bit eh, input logic [31:0] ed, input res_t r);
        chk({tag, "_timeout"}, 64'(r.to), 64'd0);
        chk({tag, "_busy_t1"}, 64'(r.busy), 64'd1);
        if (wr) begin
            chk({tag, "_wr_cmds"}, 64'(r.wrc), 64'd1);
            chk({tag, "_rd_cmds"}, 64'(r.rdc), 64'd0);
            chk({tag, "_wr_cmd"}, {last_wr_addr, last_wr_data}, {a, d});
            chk({tag, "_wr_bc"}, 64'(last_wr_bc), 64'd1);
        end else begin
            chk({tag, "_data"}, 64'(r.dout), 64'(ed));
            chk({tag, "_rd_cmds"}, 64'(r.rdc), eh ? 64'd0 : 64'd1);
            chk({tag, "_wr_cmds"}, 64'(r.wrc), 64'd0);
            if (eh) chk({tag, "_hit_lat"}, 64'(r.lat), 64'd2);
            else    chk({tag, "_rd_cmd"}, {28'd0, last_rd_bc, last_rd_addr}, {28'd0, BL, a});
        end
    endtask

    task automatic run_op(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d);
        bit          eh;
        logic [31:0] ed;
        res_t        r;
        model_predict(rd, wr, a, d, eh, ed);
        do_req(rd, wr, a, d, r);
        check_op(tag, wr, a, d, eh, ed, r);
    endtask

    task automatic count_active(output int n);
        n = 0;
        while (activity === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    vec_t tbl [17];

    initial begin
        res_t        r;
        bit          eh;
        logic [31:0] ed;
        int          n;
        int unsigned rd0, guard;
        logic [31:0] a;

        // Directed vectors: expectations stated for DEPTH=8, 32-bit words
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0, ini(32'h0000_1000), 1'b0};
        for (int i = 1; i < 8; i++)
            tbl[i] = '{1'b1, 1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0, ini(32'h0000_1000 + 32'(4 * i)), PF};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_1010, 32'h0, ini(32'h0000_1010), PF};
        tbl[11] = '{1'b1, 1'b1, 32'h0000_1020, 32'h1234_5678, 32'h0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h0000_1020, 32'h0, 32'h1234_5678, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, ini(32'hFFFF_FFF8), 1'b0};
        tbl[14] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0, ini(32'h0000_0004), PF};
        tbl[15] = '{1'b1, 1'b0, 32'h0000_0018, 32'h0, ini(32'h0000_0018), 1'b0};
        tbl[16] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0, ini(32'h0000_0014), 1'b0};

        reset_n = 1'b0; abort = 1'b0; dma_rd = 1'b0; dma_wr = 1'b0;
        dma_addr = '0; dma_dout = '0;
        repeat (3) step();

        // Reset state
        chk("rst_wait_act", {62'd0, dma_wait, activity}, 64'd0);
        chk("rst_din", 64'(dma_din), 64'd0);
        chk("rst_cmd", {mem_read, mem_write, mem_burstcount, mem_address}, 64'd0);
        chk("rst_wdata", 64'(mem_writedata), 64'd0);
        reset_n = 1'b1;
        step();

        // Vector table
        for (int i = 0; i < 17; i++) begin
            model_predict(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, eh, ed);
            do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, r);
            check_op($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                     tbl[i].exp_hit, tbl[i].exp_data, r);
        end

        // Backpressure: command must hold steady while waitrequest is high
        a = 32'h0000_5000;
        model_predict(1'b1, 1'b0, a, 32'h0, eh, ed);
        rd0 = rd_cmds;
        stall_until = cyc + 6;
        dma_rd = 1'b1; dma_addr = a;
        step();
        dma_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {26'd0, mem_read, dma_wait, mem_burstcount, mem_address},
                {26'd0, 1'b1, 1'b1, BL, a});
            step();
        end
        chk("bp_no_accept", 64'(rd_cmds - rd0), 64'd0);
        guard = 0;
        while (dma_wait !== 1'b0 && guard < 300) begin
            step();
            guard++;
        end
        chk("bp_timeout", 64'(guard < 300), 64'd1);
        chk("bp_data", 64'(dma_din), 64'(ed));
        chk("bp_rd_cmds", 64'(rd_cmds - rd0), 64'd1);

        // Abort mid-burst, a read during the drain is dropped
        rd0 = rd_cmds;
        beat_limit = beats_sent + (PF ? 3 : 0);
        dma_rd = 1'b1; dma_addr = 32'h0000_6000;
        step();
        dma_rd = 1'b0;
        guard = 0;
        while (!(rd_cmds > rd0 && beats_sent == beat_limit) && guard < 300) begin
            step();
            guard++;
        end
        chk("ab_setup_timeout", 64'(guard < 300), 64'd1);
        step();
        chk("ab_busy_before", 64'(dma_wait), 64'd1);
        abort = 1'b1;
        beat_limit = 32'hFFFF_FFFF;
        step();
        abort = 1'b0;
        m_valid = 1'b0;
        chk("ab_wait_cleared", 64'(dma_wait), 64'd0);
        dma_rd = 1'b1; dma_addr = 32'h0000_2000;
        step();
        dma_rd = 1'b0;
        chk("ab_drain_ignores_rd", 64'(dma_wait), 64'd0);
        guard = 0;
        while (addr_q.size() > 0 && guard < 300) begin
            step();
            guard++;
        end
        repeat (3) step();
        chk("ab_no_new_burst", 64'(rd_cmds - rd0), 64'd1);
        chk("ab_idle_wait", 64'(dma_wait), 64'd0);
        run_op("ab_reburst", 1'b1, 1'b0, 32'h0000_1000, 32'h0);

        // Activity stretch: exactly 10 cycles after the fall
        run_op("act_wr", 1'b0, 1'b1, 32'h0000_4000, 32'hA5A5_0001);
        count_active(n);
        chk("act_hold", 64'(n), 64'd10);
        run_op("act_rd1", 1'b1, 1'b0, 32'h0000_4000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("act_still_high", 64'(activity), 64'd1);
            step();
        end
        run_op("act_rd2", 1'b1, 1'b0, 32'h0000_4004, 32'h0);
        count_active(n);
        chk("act_retrigger", 64'(n), 64'd10);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            a   = 32'h0000_3000 + 32'(4 * $urandom_range(0, 63));
            run_op($sformatf("rnd%0d", i), sel != 7 && sel != 8, sel >= 7, a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
